poly_sampler_engine: RTL

//  N-voice polyphonic sample-playback engine. It replaces the single-note address control and the fixed multi-note producer.
//  On each sample_tick it reads one SRAM word per voice, mixes the words with saturation and emits one audio word.
//  The audio word goes to the codec driver.

---
 rtl/poly_sampler_engine.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/poly_sampler_engine.sv
// poly_sampler_engine
// -------------------
// N-voice polyphonic sample-playback engine. On every sample_tick it reads one
// SRAM word per voice, sums the words in a widened accumulator, clamps the sum
// to the signed DATA_W range and presents it on audio_data with a one-cycle
// audio_valid pulse. Voice v follows key slot v of the keycode bus. A note is
// stored in its own 2**NOTE_SHIFT word region, and the SRAM address is
// {keycode, phase}. A note either stops after its last sample or loops
// back to phase 0 (LOOP).
//
// Ports
//   Clk           system clock
//   Reset         synchronous, active-high reset
//   init          clears voices, phases and key history (taken only when idle)
//   sample_tick   one-cycle strobe requesting the next audio sample
//   keycode       NUM_VOICES key slots, 8 bits each, 0 = no key
//   sram_data     SRAM read data, valid READ_LAT cycles after the address
//   sram_address  SRAM read address {key, phase}
//   sram_oe_n     SRAM output enable, active-low
//   audio_data    mixed and saturated sample, held between frames
//   audio_valid   one-cycle pulse when audio_data updates
//   busy          a frame is in progress
//   overrun       one-cycle pulse when a tick arrived while busy and was dropped
//   voice_active  per-voice playing flag

module poly_sampler_engine #(
  parameter int NUM_VOICES = 4,
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 20,
  parameter int NOTE_SHIFT = 12,
  parameter int NOTE_LEN   = 4096,
  parameter int READ_LAT   = 2,
  parameter int LOOP       = 0
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    init,
  input  logic                    sample_tick,
  input  logic [8*NUM_VOICES-1:0] keycode,
  input  logic [DATA_W-1:0]       sram_data,
  output logic [ADDR_W-1:0]       sram_address,
  output logic                    sram_oe_n,
  output logic [DATA_W-1:0]       audio_data,
  output logic                    audio_valid,
  output logic                    busy,
  output logic                    overrun,
  output logic [NUM_VOICES-1:0]   voice_active
);

  // Accumulator carries enough headroom for NUM_VOICES full-scale samples.
  localparam int ACC_W  = DATA_W + $clog2(NUM_VOICES);
  localparam int VIDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int WCNT_W = $clog2(READ_LAT) + 1;

  localparam logic [NOTE_SHIFT-1:0] LAST_PHASE = NOTE_SHIFT'(NOTE_LEN - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'({1'b0, {(DATA_W-1){1'b1}}});
  localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - ACC_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ADDR,
    WAIT,
    SAT
  } state_t;

  state_t                                state_q, state_d;
  logic [VIDX_W-1:0]                     voice_q, voice_d;
  logic [WCNT_W-1:0]                     waitCnt_q, waitCnt_d;
  logic signed [ACC_W-1:0]               acc_q, acc_d;
  logic [NUM_VOICES-1:0][7:0]            keyHist_q, keyHist_d;
  logic [NUM_VOICES-1:0][NOTE_SHIFT-1:0] phase_q, phase_d;
  logic [NUM_VOICES-1:0]                 active_q, active_d;
  logic [DATA_W-1:0]                     audio_q, audio_d;
  logic                                  valid_q, valid_d;
  logic                                  overrun_q, overrun_d;

  logic signed [ACC_W-1:0]               sampleExt;
  logic [7:0]                            slotKey;

  // State register. Reset aborts any frame in progress, so no audio_valid
  // pulse can follow a reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      voice_q   <= '0;
      waitCnt_q <= '0;
      acc_q     <= '0;
      keyHist_q <= '0;
      phase_q   <= '0;
      active_q  <= '0;
      audio_q   <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      voice_q   <= voice_d;
      waitCnt_q <= waitCnt_d;
      acc_q     <= acc_d;
      keyHist_q <= keyHist_d;
      phase_q   <= phase_d;
      active_q  <= active_d;
      audio_q   <= audio_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  // Frame sequencer. The key history doubles as the frame's keycode snapshot:
  // it is written in LOAD and only read back while the frame runs, so later
  // keycode changes cannot reach the addresses of the current frame.
  always_comb begin
    state_d   = state_q;
    voice_d   = voice_q;
    waitCnt_d = waitCnt_q;
    acc_d     = acc_q;
    keyHist_d = keyHist_q;
    phase_d   = phase_q;
    active_d  = active_q;
    audio_d   = audio_q;
    valid_d   = 1'b0;
    overrun_d = sample_tick && (state_q != IDLE);
    sampleExt = ACC_W'($signed(sram_data));
    slotKey   = '0;

    case (state_q)
      IDLE: begin
        if (init) begin
          active_d  = '0;
          phase_d   = '0;
          keyHist_d = '0;
        end
        if (sample_tick) begin
          state_d = LOAD;
        end
      end

      // A new nonzero key in a slot retriggers that voice from phase 0; a
      // released slot silences its voice; an unchanged key keeps playing.
      LOAD: begin
        for (int v = 0; v < NUM_VOICES; v++) begin
          slotKey = keycode[8*v +: 8];
          if (slotKey == 8'd0) begin
            active_d[v] = 1'b0;
          end else if (slotKey != keyHist_q[v]) begin
            active_d[v] = 1'b1;
            phase_d[v]  = '0;
          end
          keyHist_d[v] = slotKey;
        end
        acc_d   = '0;
        voice_d = '0;
        state_d = ADDR;
      end

      ADDR: begin
        waitCnt_d = WCNT_W'(1);
        state_d   = WAIT;
      end

      // The last WAIT cycle is the one on which sram_data answers the address
      // issued in ADDR. A one-shot note that reaches its final sample drops
      // out with its phase parked until the slot gets a new key.
      WAIT: begin
        if (waitCnt_q == WCNT_W'(READ_LAT)) begin
          if (active_q[voice_q]) begin
            acc_d = acc_q + sampleExt;
            if (phase_q[voice_q] == LAST_PHASE) begin
              if (LOOP != 0) begin
                phase_d[voice_q] = '0;
              end else begin
                active_d[voice_q] = 1'b0;
              end
            end else begin
              phase_d[voice_q] = phase_q[voice_q] + NOTE_SHIFT'(1);
            end
          end
          if (voice_q == VIDX_W'(NUM_VOICES - 1)) begin
            state_d = SAT;
          end else begin
            voice_d = voice_q + VIDX_W'(1);
            state_d = ADDR;
          end
        end else begin
          waitCnt_d = waitCnt_q + WCNT_W'(1);
        end
      end

      SAT: begin
        if (acc_q > SAT_MAX) begin
          audio_d = SAT_MAX[DATA_W-1:0];
        end else if (acc_q < SAT_MIN) begin
          audio_d = SAT_MIN[DATA_W-1:0];
        end else begin
          audio_d = acc_q[DATA_W-1:0];
        end
        valid_d = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // SRAM interface. The address and enable stay stable from ADDR through the
  // WAIT cycles of a voice; an inactive voice still shows its address but
  // keeps the SRAM disabled.
  always_comb begin
    sram_address = '0;
    sram_oe_n    = 1'b1;
    if ((state_q == ADDR) || (state_q == WAIT)) begin
      sram_address = ADDR_W'({keyHist_q[voice_q], phase_q[voice_q]});
      sram_oe_n    = ~active_q[voice_q];
    end
  end

  assign audio_data   = audio_q;
  assign audio_valid  = valid_q;
  assign busy         = (state_q != IDLE);
  assign overrun      = overrun_q;
  assign voice_active = active_q;

endmodule
